// File: rtl/can_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | can_tx_arbiter: round-robin arbiter of NREQ one-word slots onto one CAN  |
// | TX buffer port, with per-word acceptance timeout and drop reporting.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module can_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_data,
  output logic                 can_tx_valid,
  input  logic                 can_tx_ready,
  output logic [31:0]          can_tx_data,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 drop_pulse,
  output logic [IDW-1:0]       drop_id
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [31:0]    TO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  state_t          state;
  logic [NREQ-1:0] slot_full;
  logic [31:0]     slot_data [NREQ];
  logic [IDW-1:0]  last_grant;
  logic [31:0]     to_cnt;

  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  int              cand;
  logic [IDW-1:0]  cand_idx;
  logic            xfer_done;
  logic            xfer_drop;
  logic            release_slot;

  assign req_ready    = ~slot_full;
  assign busy         = (state == SEND);
  assign xfer_done    = (state == SEND) && can_tx_ready;
  assign xfer_drop    = (state == SEND) && !can_tx_ready && (to_cnt == TO_LAST);
  assign release_slot = xfer_done || xfer_drop;

  // Search starts one past the last served requester so no full slot starves.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDW'(cand);
      if (!pick_found && slot_full[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full <= '0;
      for (int i = 0; i < NREQ; i++) slot_data[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!slot_full[i]) begin
          if (req_valid[i]) begin
            slot_full[i] <= 1'b1;
            slot_data[i] <= req_data[32*i +: 32];
          end
        end else if (release_slot && (grant_id == IDW'(i))) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      can_tx_valid <= 1'b0;
      can_tx_data  <= '0;
      grant_id     <= '0;
      last_grant   <= LAST_IDX;
      drop_pulse   <= 1'b0;
      drop_id      <= '0;
      to_cnt       <= '0;
    end else begin
      drop_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && pick_found) begin
            state        <= SEND;
            can_tx_valid <= 1'b1;
            can_tx_data  <= slot_data[pick_idx];
            grant_id     <= pick_idx;
            to_cnt       <= '0;
          end
        end
        SEND: begin
          // Acceptance wins over a timeout landing in the same cycle.
          if (can_tx_ready) begin
            state        <= IDLE;
            can_tx_valid <= 1'b0;
            last_grant   <= grant_id;
            to_cnt       <= '0;
          end else if (to_cnt == TO_LAST) begin
            state        <= IDLE;
            can_tx_valid <= 1'b0;
            last_grant   <= grant_id;
            drop_pulse   <= 1'b1;
            drop_id      <= grant_id;
            to_cnt       <= '0;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        default: begin
          state        <= IDLE;
          can_tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_can_tx_arbiter.sv
`default_nettype none
// Testbench for can_tx_arbiter: directed vector table, corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_can_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int TIMEOUT_A = 8;
  localparam int TIMEOUT_B = 16;

  logic         clk = 1'b0;
  logic         rst, enable, can_tx_ready;
  logic [3:0]   req_valid;
  logic [127:0] req_data;

  logic [3:0]   req_ready, req_ready_b;
  logic         can_tx_valid, can_tx_valid_b;
  logic [31:0]  can_tx_data, can_tx_data_b;
  logic [1:0]   grant_id, grant_id_b, drop_id, drop_id_b;
  logic         busy, busy_b, drop_pulse, drop_pulse_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  can_tx_arbiter #(.NREQ(NREQ), .IDW(2), .TIMEOUT(TIMEOUT_A)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .can_tx_valid(can_tx_valid), .can_tx_ready(can_tx_ready), .can_tx_data(can_tx_data),
    .grant_id(grant_id), .busy(busy), .drop_pulse(drop_pulse), .drop_id(drop_id)
  );

  can_tx_arbiter #(.NREQ(NREQ), .IDW(2), .TIMEOUT(TIMEOUT_B)) dut_b (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_data(req_data),
    .can_tx_valid(can_tx_valid_b), .can_tx_ready(can_tx_ready), .can_tx_data(can_tx_data_b),
    .grant_id(grant_id_b), .busy(busy_b), .drop_pulse(drop_pulse_b), .drop_id(drop_id_b)
  );

  // Behavioural model of dut: who holds a word, who is on the bus, how long.
  logic [3:0]  m_full;
  logic [31:0] m_slot [4];
  bit          m_send;
  logic [31:0] m_out;
  int          m_gid, m_last, m_wait, m_did;
  bit          m_dp;

  task automatic model_step();
    bit          done, drop;
    int          pick, idx;
    logic [31:0] pick_word;
    if (rst) begin
      m_full = '0; m_send = 0; m_out = '0; m_gid = 0; m_last = NREQ - 1;
      m_wait = 0; m_dp = 0; m_did = 0;
      for (int i = 0; i < 4; i++) m_slot[i] = '0;
      return;
    end
    done = m_send && can_tx_ready;
    drop = m_send && !can_tx_ready && (m_wait == TIMEOUT_A - 1);
    pick = -1;
    pick_word = '0;
    if (!m_send && enable) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (pick < 0 && m_full[idx]) begin
          pick = idx;
          pick_word = m_slot[idx];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!m_full[i]) begin
        if (req_valid[i]) begin
          m_full[i] = 1'b1;
          m_slot[i] = req_data[32*i +: 32];
        end
      end else if ((done || drop) && m_gid == i) begin
        m_full[i] = 1'b0;
      end
    end
    m_dp = drop;
    if (drop) m_did = m_gid;
    if (m_send) begin
      if (done || drop) begin
        m_send = 0;
        m_last = m_gid;
      end else begin
        m_wait++;
      end
    end else if (pick >= 0) begin
      m_send = 1; m_gid = pick; m_out = pick_word; m_wait = 0;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [63:0] act_v, exp_v;
    model_step();
    @(posedge clk);
    #1;
    act_v = {21'd0, can_tx_valid, can_tx_data, grant_id, busy, drop_pulse, drop_id, req_ready};
    exp_v = {21'd0, m_send, m_out, 2'(m_gid), m_send, m_dp, 2'(m_did), ~m_full};
    check("cycle_model", act_v, exp_v);
  endtask

  task automatic drive(input logic r, input logic en, input logic [3:0] rv,
                       input logic [127:0] d, input logic rdy);
    rst = r; enable = en; req_valid = rv; req_data = d; can_tx_ready = rdy;
  endtask

  typedef struct {
    logic         rst;
    logic         en;
    logic [3:0]   rv;
    logic [127:0] data;
    logic         rdy;
    logic         exp_valid;
    logic [31:0]  exp_data;
    logic [1:0]   exp_gid;
    logic [3:0]   exp_ready;
  } vec_t;

  vec_t vecs [15];

  localparam logic [127:0] D_SW = {32'h0, 32'h0000_0001, 32'h0, 32'h0};
  localparam logic [127:0] D_RR = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 4'b0000, 128'h0, 1'b1, 1'b0, 32'h0,  2'd0, 4'b1111};
    vecs[1]  = '{1'b0, 1'b1, 4'b0100, D_SW,   1'b1, 1'b0, 32'h0,  2'd0, 4'b1011};
    vecs[2]  = '{1'b0, 1'b1, 4'b0000, 128'h0, 1'b1, 1'b1, 32'h1,  2'd2, 4'b1011};
    vecs[3]  = '{1'b0, 1'b1, 4'b0000, 128'h0, 1'b1, 1'b0, 32'h1,  2'd2, 4'b1111};
    vecs[4]  = '{1'b0, 1'b1, 4'b0000, 128'h0, 1'b1, 1'b0, 32'h1,  2'd2, 4'b1111};
    vecs[5]  = '{1'b1, 1'b1, 4'b0000, 128'h0, 1'b1, 1'b0, 32'h0,  2'd0, 4'b1111};
    vecs[6]  = '{1'b0, 1'b1, 4'b1111, D_RR,   1'b1, 1'b0, 32'h0,  2'd0, 4'b0000};
    vecs[7]  = '{1'b0, 1'b1, 4'b0000, 128'h0, 1'b1, 1'b1, 32'hA0, 2'd0, 4'b0000};
    vecs[8]  = '{1'b0, 1'b1, 4'b0000, 128'h0, 1'b1, 1'b0, 32'hA0, 2'd0, 4'b0001};
    vecs[9]  = '{1'b0, 1'b1, 4'b0000, 128'h0, 1'b1, 1'b1, 32'hA1, 2'd1, 4'b0001};
    vecs[10] = '{1'b0, 1'b1, 4'b0000, 128'h0, 1'b1, 1'b0, 32'hA1, 2'd1, 4'b0011};
    vecs[11] = '{1'b0, 1'b1, 4'b0000, 128'h0, 1'b1, 1'b1, 32'hA2, 2'd2, 4'b0011};
    vecs[12] = '{1'b0, 1'b1, 4'b0000, 128'h0, 1'b1, 1'b0, 32'hA2, 2'd2, 4'b0111};
    vecs[13] = '{1'b0, 1'b1, 4'b0000, 128'h0, 1'b1, 1'b1, 32'hA3, 2'd3, 4'b0111};
    vecs[14] = '{1'b0, 1'b1, 4'b0000, 128'h0, 1'b1, 1'b0, 32'hA3, 2'd3, 4'b1111};

    drive(1'b1, 1'b1, 4'b0000, 128'h0, 1'b1);

    // Single word then round-robin, from the table.
    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].rst, vecs[v].en, vecs[v].rv, vecs[v].data, vecs[v].rdy);
      tick();
      check($sformatf("vec%0d", v),
            {23'd0, can_tx_valid, can_tx_data, grant_id, req_ready},
            {23'd0, vecs[v].exp_valid, vecs[v].exp_data, vecs[v].exp_gid, vecs[v].exp_ready});
    end

    // Backpressure on the long-timeout instance: ten stalled cycles then accept.
    drive(1'b1, 1'b1, 4'b0000, 128'h0, 1'b0); tick();
    drive(1'b0, 1'b1, 4'b0010, {32'h0, 32'h0, 32'h5A5A_0001, 32'h0}, 1'b0); tick();
    drive(1'b0, 1'b1, 4'b0000, 128'h0, 1'b0); tick();
    check("bp_grant", {can_tx_valid_b, grant_id_b}, {1'b1, 2'd1});
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold", {can_tx_valid_b, can_tx_data_b, req_ready_b[1], drop_pulse_b},
            {1'b1, 32'h5A5A_0001, 1'b0, 1'b0});
    end
    can_tx_ready = 1'b1; tick();
    check("bp_done", {can_tx_valid_b, req_ready_b[1], drop_pulse_b}, {1'b0, 1'b1, 1'b0});

    // Timeout drop on the short-timeout instance.
    drive(1'b1, 1'b1, 4'b0000, 128'h0, 1'b0); tick();
    drive(1'b0, 1'b1, 4'b1100, {32'hD3, 32'hD2, 64'h0}, 1'b0); tick();
    drive(1'b0, 1'b1, 4'b0000, 128'h0, 1'b0); tick();
    check("to_grant", {can_tx_valid, grant_id}, {1'b1, 2'd2});
    for (int i = 0; i < TIMEOUT_A - 1; i++) begin
      tick();
      check("to_wait", {can_tx_valid, drop_pulse}, {1'b1, 1'b0});
    end
    tick();
    check("to_drop", {drop_pulse, drop_id, can_tx_valid, req_ready[2]}, {1'b1, 2'd2, 1'b0, 1'b1});
    tick();
    check("to_next", {can_tx_valid, grant_id, can_tx_data, drop_pulse, drop_id},
          {1'b1, 2'd3, 32'hD3, 1'b0, 2'd2});

    // Ready arriving exactly on the last permitted cycle completes normally.
    for (int i = 0; i < TIMEOUT_A - 1; i++) tick();
    can_tx_ready = 1'b1; tick();
    check("coinc", {drop_pulse, can_tx_valid, req_ready[3], drop_id}, {1'b0, 1'b0, 1'b1, 2'd2});

    // Reset while a word is on the bus.
    drive(1'b0, 1'b1, 4'b0010, {32'h0, 32'h0, 32'h77, 32'h0}, 1'b0); tick();
    drive(1'b0, 1'b1, 4'b0000, 128'h0, 1'b0); tick();
    check("rst_pre", {can_tx_valid, grant_id}, {1'b1, 2'd1});
    drive(1'b1, 1'b1, 4'b0000, 128'h0, 1'b0); tick();
    check("rst_vals", {21'd0, can_tx_valid, can_tx_data, grant_id, busy, drop_pulse, drop_id, req_ready},
          {21'd0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 2'd0, 4'b1111});
    drive(1'b0, 1'b1, 4'b0000, 128'h0, 1'b1); tick();
    check("rst_flush", {can_tx_valid, drop_pulse}, {1'b0, 1'b0});

    // Enable gating, including enable dropping mid-transfer.
    drive(1'b0, 1'b0, 4'b1111, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1'b1); tick();
    drive(1'b0, 1'b0, 4'b0000, 128'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en_block", {can_tx_valid, req_ready}, {1'b0, 4'b0000});
    end
    drive(1'b0, 1'b1, 4'b0000, 128'h0, 1'b0); tick();
    check("en_grant", {can_tx_valid, grant_id, can_tx_data}, {1'b1, 2'd0, 32'hE0});
    enable = 1'b0; tick();
    check("en_noabort", {can_tx_valid, grant_id}, {1'b1, 2'd0});
    can_tx_ready = 1'b1; tick();
    check("en_done", {can_tx_valid, req_ready}, {1'b0, 4'b0001});
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_hold", {25'd0, can_tx_valid}, {25'd0, 1'b0});
    end
    enable = 1'b1; tick();
    check("en_resume", {can_tx_valid, grant_id, can_tx_data}, {1'b1, 2'd1, 32'hE1});

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, 4'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
